joypad_port: RTL
================

# joypad_port

Memory-mapped responder on the CPU data/address bus implementing the two NES controller ports at $4016/$4017. It decodes CPU accesses, holds the strobe latch written at $4016, and shifts out one button bit per CPU read through an 8-bit shift register per pad. It sits beside `cpu_top` under `top`, on the far side of the `A`/`D`/`R_W_n` bus from the CPU.

## Interface
Parameters:
- `BASE_ADDR`, 16'h4016 — address of pad 1; pad 2 is `BASE_ADDR+1`.
- `OPEN_BUS`, 8'h40 — value driven on `D_out[7:1]` during reads; bit 0 is always replaced.

Ports:
- `phi0`  in  1 — sole clock; all state updates on its rising edge.
- `reset`  in  1 — synchronous, active-high.
- `bus_valid`  in  1 — one-cycle qualifier marking a CPU bus access on `A`/`R_W_n`/`D_in`.
- `A`  in  `ADDR_WIDTH` (16) — CPU address.
- `R_W_n`  in  1 — 1 = read, 0 = write.
- `D_in`  in  `REG_WIDTH` (8) — CPU write data.
- `D_out`  out  `REG_WIDTH` (8) — read response data.
- `D_oe`  out  1 — high while `D_out` is to be driven onto `D`.
- `pad1_buttons`, `pad2_buttons`  in  8 — asynchronous live button levels, 1 = pressed; bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
- `pad_strobe`  out  1 — strobe level forwarded to both controllers.

## Operation
- Input sync: each `padN_buttons` passes through a 2-flop synchronizer; the shift registers see only the synchronized value `syncN`.
- Strobe latch: a write (`bus_valid & ~R_W_n`) with `A == BASE_ADDR` sets `strobe <= D_in[0]`. `pad_strobe` mirrors `strobe`.
- Writes to `BASE_ADDR+1` and all other addresses are ignored; the block never drives `D_oe` on a write.
- Reload: every cycle `strobe == 1`, `srN <= syncN`. This also applies on the cycle the strobe write lands, using the new strobe value.
- Read of pad N (`bus_valid & R_W_n`, `A == BASE_ADDR+N-1`):
  - Next edge: `D_out <= {OPEN_BUS[7:1], srN[0]}` and `D_oe <= 1`.
  - If `strobe == 0`: `srN <= {1'b1, srN[7:1]}`.
  - If `strobe == 1`: no shift, reload wins, and the returned bit is the current A button.
- After 8 reads with strobe low, every further read returns bit 0 = 1.
- Reads to any other address: `D_oe <= 0`. `D_out` holds its last value.
- A read of one pad never disturbs the other pad's register.
- Reset sets:
  - `strobe = 0`, `pad_strobe = 0`
  - `sr1 = sr2 = 8'h00`
  - synchronizer flops = 0
  - `D_out = 8'h00`, `D_oe = 0`
- Reset mid-sequence discards the partial shift. The next strobe cycle is required before valid data.

## Timing
- Read latency: 1 cycle. `D_oe` is high for exactly the one cycle following each qualifying `bus_valid`.
- Back-to-back reads on consecutive cycles each return successive bits, with no bubble.
- Button-to-register latency: 2 cycles of synchronizer, plus 1 reload edge while strobe is high.
- Strobe write takes effect at the edge after `bus_valid`. `pad_strobe` changes at that same edge.
- `bus_valid` low: no state change except the synchronizers and the strobe-high reload.
- Reset has priority over any access in the same cycle.

## Test plan
- Reset, then read $4016 → `D_oe=1` one cycle later, `D_out=8'h40`. `D_oe` returns to 0 on the next idle cycle.
- `pad1_buttons=8'b1010_0101`; wait 3 cycles; write $4016=1 then $4016=0; 10 reads of $4016 → bit0 sequence 1,0,1,0,0,1,0,1,1,1. Data bytes are `8'h41`/`8'h40` accordingly.
- Strobe held at 1 with `pad1_buttons` A bit toggling; repeated reads of $4016 → each read returns the current synchronized A bit, and no shift occurs.
- `pad1_buttons=8'hFF`, `pad2_buttons=8'h02`; strobe 1→0; interleave reads $4017, $4016, $4017 → 0, 1, 1. Pad 2 returns its bits 0 then 1; pad 1 is unaffected.
- Write $4017=8'hFF and write $4015 → `strobe` unchanged, `D_oe` stays 0. Read $4015 → `D_oe` stays 0.
- Latch 8'hFF, read 3 times, assert `reset` for 1 cycle concurrent with a read → `D_oe=0`, `pad_strobe=0`. A following read returns `8'h40`.

Source files
------------

// File: rtl/joypad_port.sv
// NES controller ports at $4016/$4017: strobe latch, per-pad button synchronizers and
// serial shift registers read out one bit per CPU read on the D bus.
module joypad_port #(
    parameter int unsigned             ADDR_WIDTH = 16,
    parameter int unsigned             REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 16'h4016,
    parameter logic [REG_WIDTH-1:0]    OPEN_BUS   = 8'h40
) (
    input  logic                  phi0,
    input  logic                  reset,
    input  logic                  bus_valid,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  R_W_n,
    input  logic [REG_WIDTH-1:0]  D_in,
    output logic [REG_WIDTH-1:0]  D_out,
    output logic                  D_oe,
    input  logic [7:0]            pad1_buttons,
    input  logic [7:0]            pad2_buttons,
    output logic                  pad_strobe
);

    localparam logic [ADDR_WIDTH-1:0] PAD2_ADDR = BASE_ADDR + ADDR_WIDTH'(1);

    logic       strobe;
    logic       strobe_eff;
    logic       wr_strobe;
    logic [1:0] rd;
    logic [7:0] buttons [2];
    logic [7:0] sync_a  [2];
    logic [7:0] sync    [2];
    logic [7:0] sr      [2];
    logic       rd_bit;
    logic       unused_din;

    assign buttons[0] = pad1_buttons;
    assign buttons[1] = pad2_buttons;
    assign pad_strobe = strobe;

    always_comb begin
        wr_strobe  = bus_valid & ~R_W_n & (A == BASE_ADDR);
        rd[0]      = bus_valid &  R_W_n & (A == BASE_ADDR);
        rd[1]      = bus_valid &  R_W_n & (A == PAD2_ADDR);
        // The strobe write itself already counts as a strobe-high reload cycle.
        strobe_eff = wr_strobe ? D_in[0] : strobe;
        rd_bit     = rd[1] ? sr[1][0] : sr[0][0];
        unused_din = ^D_in[REG_WIDTH-1:1];
    end

    always_ff @(posedge phi0) begin
        if (reset) begin
            strobe <= 1'b0;
            D_out  <= '0;
            D_oe   <= 1'b0;
            for (int unsigned p = 0; p < 2; p++) begin
                sync_a[p] <= '0;
                sync[p]   <= '0;
                sr[p]     <= '0;
            end
        end else begin
            strobe <= strobe_eff;
            for (int unsigned p = 0; p < 2; p++) begin
                sync_a[p] <= buttons[p];
                sync[p]   <= sync_a[p];
                if (strobe_eff)
                    sr[p] <= sync[p];
                else if (rd[p])
                    sr[p] <= {1'b1, sr[p][7:1]};
            end
            if (rd[0] | rd[1]) begin
                D_oe  <= 1'b1;
                D_out <= {OPEN_BUS[REG_WIDTH-1:1], rd_bit};
            end else begin
                D_oe  <= 1'b0;
            end
        end
    end

endmodule
